// File: rtl/conv_feeder_pkg.sv
// Shared constants for the convolution operand feeder: stream data widths
// and the FSM state encoding.
package conv_feeder_pkg;

  localparam int unsigned IFM_W = 64;
  localparam int unsigned WGT_W = 32;
  localparam int unsigned ST_W  = 3;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_PRIME = 3'd1;
  localparam state_t ST_LOAD  = 3'd2;
  localparam state_t ST_START = 3'd3;
  localparam state_t ST_RUN   = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  function automatic logic state_busy(input state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/conv_feeder_stream_head.sv
// One operand stream: head register, head index, last issued SRAM address
// and exhausted tracking, prefetching one word ahead of the head.
module conv_feeder_stream_head #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_prime,
  input  logic              i_load,
  input  logic              i_run,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_count,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_head,
  output logic              o_underrun
);

  localparam int unsigned XW = ADDR_W + 1;

  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_head;
  logic              r_exh;

  logic [XW-1:0]     w_idx_p1;
  logic [XW-1:0]     w_idx_p2;
  logic [XW-1:0]     w_cnt_x;
  logic              w_strobe;
  logic              w_has_next;
  logic              w_mem_en;
  logic [ADDR_W-1:0] w_issue_addr;

  // Widened by one bit so h+2 never wraps when the count is near 2^ADDR_W.
  assign w_idx_p1   = {1'b0, r_idx} + XW'(1);
  assign w_idx_p2   = {1'b0, r_idx} + XW'(2);
  assign w_cnt_x    = {1'b0, r_count};
  assign w_strobe   = i_run && i_read;
  assign w_has_next = !r_exh && (w_idx_p1 < w_cnt_x);

  always_comb begin
    w_mem_en     = 1'b0;
    w_issue_addr = r_addr;
    if (i_prime) begin
      w_mem_en     = (r_count != '0);
      w_issue_addr = '0;
    end else if (i_load) begin
      w_mem_en     = (r_count > ADDR_W'(1));
      w_issue_addr = ADDR_W'(1);
    end else if (w_strobe && w_has_next) begin
      // Address is issued in the strobe cycle so the next word is on rdata
      // one cycle later, sustaining a strobe every cycle.
      w_mem_en     = (w_idx_p2 < w_cnt_x);
      w_issue_addr = w_idx_p2[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_head  <= '0;
      r_exh   <= 1'b0;
    end else if (i_start) begin
      r_count <= i_count;
      r_idx   <= '0;
      r_addr  <= '0;
      r_head  <= '0;
      r_exh   <= 1'b0;
    end else begin
      if (w_mem_en) begin
        r_addr <= w_issue_addr;
      end
      if (i_load) begin
        if (r_count != '0) begin
          r_head <= i_rdata;
        end else begin
          r_head <= '0;
          r_exh  <= 1'b1;
        end
      end else if (w_strobe) begin
        if (w_has_next) begin
          r_head <= i_rdata;
          r_idx  <= r_idx + ADDR_W'(1);
        end else begin
          r_head <= '0;
          r_exh  <= 1'b1;
        end
      end
    end
  end

  assign o_mem_en   = w_mem_en;
  assign o_mem_addr = w_issue_addr;
  assign o_head     = r_head;
  assign o_underrun = w_strobe && r_exh;

endmodule

// File: rtl/conv_feeder.sv
// Job sequencer feeding IFM and weight words from two SRAMs to a convolution
// accelerator, with start/done handshake and a sticky underrun flag.
module conv_feeder
  import conv_feeder_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [1:0]        job_ci,
  input  logic [1:0]        job_co,
  input  logic [ADDR_W-1:0] ifm_words,
  input  logic [ADDR_W-1:0] wgt_words,
  output logic              ifm_mem_en,
  output logic [ADDR_W-1:0] ifm_mem_addr,
  input  logic [IFM_W-1:0]  ifm_mem_rdata,
  output logic              wgt_mem_en,
  output logic [ADDR_W-1:0] wgt_mem_addr,
  input  logic [WGT_W-1:0]  wgt_mem_rdata,
  output logic              start_conv,
  output logic [1:0]        cfg_ci,
  output logic [1:0]        cfg_co,
  output logic [IFM_W-1:0]  ifm,
  output logic [WGT_W-1:0]  weight,
  input  logic              ifm_read,
  input  logic              wgt_read,
  input  logic              end_conv,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_cfg_ci;
  logic [1:0] r_cfg_co;
  logic       r_underrun;

  logic       w_go_ok;
  logic       w_prime;
  logic       w_load;
  logic       w_run;
  logic       w_ifm_unf;
  logic       w_wgt_unf;

  assign w_go_ok = (r_state == ST_IDLE) && go;
  assign w_prime = (r_state == ST_PRIME);
  assign w_load  = (r_state == ST_LOAD);
  assign w_run   = (r_state == ST_RUN);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (go) w_state_nxt = ST_PRIME;
      ST_PRIME: w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_RUN;
      ST_RUN:   if (end_conv) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cfg_ci   <= '0;
      r_cfg_co   <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_go_ok) begin
        r_cfg_ci   <= job_ci;
        r_cfg_co   <= job_co;
        r_underrun <= 1'b0;
      end else if (w_ifm_unf || w_wgt_unf) begin
        r_underrun <= 1'b1;
      end
    end
  end

  conv_feeder_stream_head #(
    .DATA_W (IFM_W),
    .ADDR_W (ADDR_W)
  ) u_ifm_head (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_go_ok),
    .i_prime    (w_prime),
    .i_load     (w_load),
    .i_run      (w_run),
    .i_read     (ifm_read),
    .i_count    (ifm_words),
    .i_rdata    (ifm_mem_rdata),
    .o_mem_en   (ifm_mem_en),
    .o_mem_addr (ifm_mem_addr),
    .o_head     (ifm),
    .o_underrun (w_ifm_unf)
  );

  conv_feeder_stream_head #(
    .DATA_W (WGT_W),
    .ADDR_W (ADDR_W)
  ) u_wgt_head (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_go_ok),
    .i_prime    (w_prime),
    .i_load     (w_load),
    .i_run      (w_run),
    .i_read     (wgt_read),
    .i_count    (wgt_words),
    .i_rdata    (wgt_mem_rdata),
    .o_mem_en   (wgt_mem_en),
    .o_mem_addr (wgt_mem_addr),
    .o_head     (weight),
    .o_underrun (w_wgt_unf)
  );

  assign start_conv = (r_state == ST_START);
  assign done       = (r_state == ST_DONE);
  assign busy       = state_busy(r_state);
  assign cfg_ci     = r_cfg_ci;
  assign cfg_co     = r_cfg_co;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_conv_feeder.sv
// Directed bench for conv_feeder with 1-cycle-latency SRAM models where
// word k holds k+1.
module tb_conv_feeder;

  logic        clk;
  logic        rst_n;
  logic        go;
  logic [1:0]  job_ci;
  logic [1:0]  job_co;
  logic [15:0] ifm_words;
  logic [15:0] wgt_words;
  logic        ifm_mem_en;
  logic [15:0] ifm_mem_addr;
  logic [63:0] ifm_mem_rdata = '0;
  logic        wgt_mem_en;
  logic [15:0] wgt_mem_addr;
  logic [31:0] wgt_mem_rdata = '0;
  logic        start_conv;
  logic [1:0]  cfg_ci;
  logic [1:0]  cfg_co;
  logic [63:0] ifm;
  logic [31:0] weight;
  logic        ifm_read;
  logic        wgt_read;
  logic        end_conv;
  logic        busy;
  logic        done;
  logic        underrun;

  int n_chk  = 0;
  int n_fail = 0;
  int ifm_iss [0:16];
  int wgt_iss [0:16];
  int ifm_base[0:16];
  int wgt_base[0:16];
  int cyc;

  conv_feeder #(.ADDR_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .go            (go),
    .job_ci        (job_ci),
    .job_co        (job_co),
    .ifm_words     (ifm_words),
    .wgt_words     (wgt_words),
    .ifm_mem_en    (ifm_mem_en),
    .ifm_mem_addr  (ifm_mem_addr),
    .ifm_mem_rdata (ifm_mem_rdata),
    .wgt_mem_en    (wgt_mem_en),
    .wgt_mem_addr  (wgt_mem_addr),
    .wgt_mem_rdata (wgt_mem_rdata),
    .start_conv    (start_conv),
    .cfg_ci        (cfg_ci),
    .cfg_co        (cfg_co),
    .ifm           (ifm),
    .weight        (weight),
    .ifm_read      (ifm_read),
    .wgt_read      (wgt_read),
    .end_conv      (end_conv),
    .busy          (busy),
    .done          (done),
    .underrun      (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 17; i++) begin
      ifm_iss[i] = 0;
      wgt_iss[i] = 0;
    end
  end

  always @(posedge clk) begin
    if (ifm_mem_en === 1'b1) begin
      ifm_mem_rdata <= 64'(ifm_mem_addr) + 64'd1;
      if (ifm_mem_addr < 16'd16) ifm_iss[ifm_mem_addr] = ifm_iss[ifm_mem_addr] + 1;
      else                       ifm_iss[16] = ifm_iss[16] + 1;
    end
    if (wgt_mem_en === 1'b1) begin
      wgt_mem_rdata <= 32'(wgt_mem_addr) + 32'd1;
      if (wgt_mem_addr < 16'd16) wgt_iss[wgt_mem_addr] = wgt_iss[wgt_mem_addr] + 1;
      else                       wgt_iss[16] = wgt_iss[16] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] n_ifm, input logic [15:0] n_wgt,
                           input logic [1:0] ci, input logic [1:0] co, output int cycles);
    for (int i = 0; i < 17; i++) begin
      ifm_base[i] = ifm_iss[i];
      wgt_base[i] = wgt_iss[i];
    end
    ifm_words = n_ifm;
    wgt_words = n_wgt;
    job_ci    = ci;
    job_co    = co;
    go        = 1'b1;
    tick();
    go     = 1'b0;
    cycles = 1;
    while (!start_conv && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] ifm_exp [4];
    logic [31:0] wgt_exp [3];
    int          tot;
    ifm_exp = '{64'd2, 64'd3, 64'd4, 64'd0};
    wgt_exp = '{32'd2, 32'd0, 32'd0};

    rst_n = 1'b0; go = 1'b0; job_ci = '0; job_co = '0;
    ifm_words = '0; wgt_words = '0;
    ifm_read = 1'b0; wgt_read = 1'b0; end_conv = 1'b0;
    #3;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_start", 64'(start_conv), 64'd0);
    check_eq("rst_underrun", 64'(underrun), 64'd0);
    check_eq("rst_ifm", ifm, 64'd0);
    check_eq("rst_weight", 64'(weight), 64'd0);
    check_eq("rst_mem_en", 64'({ifm_mem_en, wgt_mem_en}), 64'd0);
    check_eq("rst_addr", 64'({ifm_mem_addr, wgt_mem_addr}), 64'd0);
    check_eq("rst_cfg", 64'({cfg_ci, cfg_co}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Job 1: ifm_words=4, wgt_words=2
    start_job(16'd4, 16'd2, 2'd2, 2'd1, cyc);
    check_eq("j1_start_latency", 64'(cyc), 64'd3);
    check_eq("j1_ifm_at_start", ifm, 64'd1);
    check_eq("j1_wgt_at_start", 64'(weight), 64'd1);
    check_eq("j1_cfg_ci", 64'(cfg_ci), 64'd2);
    check_eq("j1_cfg_co", 64'(cfg_co), 64'd1);
    check_eq("j1_busy", 64'(busy), 64'd1);
    tick();
    check_eq("j1_start_pulse_len", 64'(start_conv), 64'd0);

    ifm_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("j1_ifm_en_%0d", i), 64'(ifm_mem_en), (i < 2) ? 64'd1 : 64'd0);
      if (i < 2) check_eq($sformatf("j1_ifm_addr_%0d", i), 64'(ifm_mem_addr), 64'(i + 2));
      tick();
      check_eq($sformatf("j1_ifm_head_%0d", i), ifm, ifm_exp[i]);
      check_eq($sformatf("j1_ifm_unf_%0d", i), 64'(underrun), 64'd0);
    end
    ifm_read = 1'b0;
    for (int a = 0; a < 5; a++)
      check_eq($sformatf("j1_ifm_issue_%0d", a), 64'(ifm_iss[a] - ifm_base[a]), (a < 4) ? 64'd1 : 64'd0);
    check_eq("j1_ifm_issue_hi", 64'(ifm_iss[16] - ifm_base[16]), 64'd0);

    for (int i = 0; i < 3; i++) begin
      wgt_read = 1'b1;
      tick();
      wgt_read = 1'b0;
      check_eq($sformatf("j1_wgt_head_%0d", i), 64'(weight), 64'(wgt_exp[i]));
      check_eq($sformatf("j1_wgt_unf_%0d", i), 64'(underrun), (i == 2) ? 64'd1 : 64'd0);
    end
    for (int a = 0; a < 3; a++)
      check_eq($sformatf("j1_wgt_issue_%0d", a), 64'(wgt_iss[a] - wgt_base[a]), (a < 2) ? 64'd1 : 64'd0);

    ifm_words = 16'd9; job_ci = 2'd3; go = 1'b1;
    tick();
    go = 1'b0;
    check_eq("j1_go_in_run_cfg", 64'(cfg_ci), 64'd2);
    check_eq("j1_go_in_run_unf", 64'(underrun), 64'd1);
    check_eq("j1_go_in_run_start", 64'(start_conv), 64'd0);
    end_conv = 1'b1;
    tick();
    end_conv = 1'b0;
    check_eq("j1_done", 64'(done), 64'd1);
    check_eq("j1_busy_in_done", 64'(busy), 64'd1);
    tick();
    check_eq("j1_done_len", 64'(done), 64'd0);
    check_eq("j1_busy_after", 64'(busy), 64'd0);
    end_conv = 1'b1;
    tick();
    end_conv = 1'b0;
    check_eq("idle_end_conv_done", 64'(done), 64'd0);
    check_eq("idle_end_conv_busy", 64'(busy), 64'd0);

    // Job 2: empty IFM stream
    start_job(16'd0, 16'd3, 2'd1, 2'd3, cyc);
    check_eq("j2_start_latency", 64'(cyc), 64'd3);
    check_eq("j2_ifm_at_start", ifm, 64'd0);
    check_eq("j2_wgt_at_start", 64'(weight), 64'd1);
    check_eq("j2_unf_cleared", 64'(underrun), 64'd0);
    tot = 0;
    for (int a = 0; a < 17; a++) tot += ifm_iss[a] - ifm_base[a];
    check_eq("j2_ifm_no_issue", 64'(tot), 64'd0);
    ifm_read = 1'b1;
    tick();
    ifm_read = 1'b0;
    check_eq("j2_strobe_in_start", 64'(underrun), 64'd0);
    ifm_read = 1'b1;
    tick();
    ifm_read = 1'b0;
    check_eq("j2_unf_set", 64'(underrun), 64'd1);
    check_eq("j2_ifm_zero", ifm, 64'd0);
    check_eq("j2_wgt_hold", 64'(weight), 64'd1);
    wgt_read = 1'b1;
    tick();
    wgt_read = 1'b0;
    check_eq("j2_wgt_adv", 64'(weight), 64'd2);
    end_conv = 1'b1;
    tick();
    end_conv = 1'b0;
    tick();

    // Job 3: reset mid-run, then restart
    start_job(16'd4, 16'd2, 2'd0, 2'd2, cyc);
    tick();
    ifm_read = 1'b1;
    tick();
    tick();
    ifm_read = 1'b0;
    check_eq("j3_ifm_before_rst", ifm, 64'd3);
    rst_n = 1'b0;
    #2;
    check_eq("j3_rst_ifm", ifm, 64'd0);
    check_eq("j3_rst_weight", 64'(weight), 64'd0);
    check_eq("j3_rst_busy", 64'(busy), 64'd0);
    check_eq("j3_rst_cfg_co", 64'(cfg_co), 64'd0);
    check_eq("j3_rst_mem", 64'({ifm_mem_en, wgt_mem_en, ifm_mem_addr}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("j3_no_done", 64'(done), 64'd0);
    start_job(16'd4, 16'd2, 2'd1, 2'd1, cyc);
    check_eq("j3_restart_latency", 64'(cyc), 64'd3);
    check_eq("j3_restart_ifm", ifm, 64'd1);
    check_eq("j3_restart_addr0", 64'(ifm_iss[0] - ifm_base[0]), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_feeder.md
CONV_FEEDER -- requirements
Module: conv_feeder

Interface
REQ-001 Parameter ADDR_W, default 16: word-address width of both operand memories.
REQ-002 clk  in  1  single clock; every flop is rising-edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 go  in  1  one-cycle job start pulse; honoured only in IDLE.
REQ-005 job_ci / job_co  in  2 / 2  channel configs; latched on an accepted go.
REQ-006 ifm_words / wgt_words  in  ADDR_W / ADDR_W  word counts per job; latched on go; 0 is legal.
REQ-007 ifm_mem_en, ifm_mem_addr  out  1, ADDR_W  IFM SRAM read request; data returns next cycle.
REQ-008 ifm_mem_rdata  in  64  IFM SRAM read data (8 row bytes, row0 in [7:0]).
REQ-009 wgt_mem_en, wgt_mem_addr  out  1, ADDR_W  weight SRAM read request; 1-cycle latency.
REQ-010 wgt_mem_rdata  in  32  weight SRAM read data (4 filter-row bytes, row0 in [7:0]).
REQ-011 start_conv  out  1  one-cycle accelerator start pulse.
REQ-012 cfg_ci / cfg_co  out  2 / 2  latched job config, stable from start_conv to done.
REQ-013 ifm / weight  out  64 / 32  current head word presented to the accelerator.
REQ-014 ifm_read / wgt_read  in  1 / 1  accelerator consume strobes; the head is sampled in the same cycle.
REQ-015 end_conv  in  1  accelerator completion pulse.
REQ-016 busy / done / underrun  out  1 / 1 / 1  job active; one-cycle completion pulse; sticky error flag.

Function
REQ-017 FSM states: IDLE, PRIME, LOAD, START, RUN, DONE; exactly one state active.
REQ-018 IDLE->PRIME on go: latch the config and counts, clear underrun, issue address 0 on both memories.
REQ-019 PRIME->LOAD after one cycle: issue address 1 on both memories.
REQ-020 In LOAD: head <= rdata for any stream whose count is non-zero; head = 0 and the stream is marked exhausted for any stream whose count is 0.
REQ-021 LOAD->START after one cycle; START drives start_conv=1 for exactly one cycle; START->RUN.
REQ-022 Each stream keeps head index h and address register h+1, so the word for h+1 is always available on rdata.
REQ-023 In RUN, on a read strobe with h+1 < count: head <= rdata, h <= h+1, issue address h+2.
REQ-024 A strobe on the final word (h+1 = count) sets head to 0 and marks the stream exhausted.
REQ-025 A strobe on an exhausted stream leaves head at 0 and sets underrun, which holds until the next accepted go.
REQ-026 Back-to-back strobes every cycle are sustained with no bubbles; ifm and wgt streams advance independently and may strobe in the same cycle.
REQ-027 mem_en is high only in the cycle an address is issued; no address at or beyond count is issued.
REQ-028 RUN->DONE on end_conv; DONE pulses done=1 for one cycle, then goes to IDLE. end_conv outside RUN is ignored.
REQ-029 busy=1 in PRIME, LOAD, START, RUN and DONE.
REQ-030 go while busy is ignored.
REQ-031 Strobes outside RUN are ignored and do not set underrun.
REQ-032 Address arithmetic is unsigned ADDR_W-bit and does not wrap within a job, because count <= 2^ADDR_W - 1.

Reset
REQ-033 On rst_n low, immediately: state=IDLE; start_conv, done, busy, underrun, mem_en = 0; ifm, weight, addresses, cfg_ci, cfg_co = 0.
REQ-034 Reset mid-job aborts the job with no done pulse; the next go starts cleanly from address 0.

Structure
REQ-035 The FSM state encoding and the IFM_W=64 / WGT_W=32 constants live in the shared accelerator package.
REQ-036 One sub-module, STREAM_HEAD, parameterised by data width, holds the head register, index counter, address and exhausted logic; it is instantiated twice (IFM and weight).

Verification
REQ-037 go with ifm_words=4, wgt_words=2, SRAM word k = k+1 -> start_conv appears 3 cycles after go; ifm=1 and weight=1 at start_conv.
REQ-038 ifm_read held high for 4 cycles -> ifm shows 2, 3, 4, then 0; underrun stays 0; addresses 0..3 are each issued exactly once.
REQ-039 wgt_read asserted 3 times with wgt_words=2 -> weight shows 2, then 0; underrun=1 after the third strobe.
REQ-040 end_conv in RUN -> done=1 on the next cycle for one cycle; busy=0 afterward; a go during RUN has no effect.
REQ-041 rst_n low during RUN after 2 reads -> all outputs 0 immediately; a new go refetches address 0 and presents word 1.
REQ-042 ifm_words=0 -> ifm=0 at start_conv; a first ifm_read sets underrun; the weight stream is unaffected.
